// File: rtl/raycast_pkg.sv
// Shared raycaster types: screen geometry defaults, per-column wall record, writer FSM states.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package raycast_pkg;

  // Screen geometry defaults; both column_buffer and process_element size themselves from these.
  localparam int unsigned SCREEN_WIDTH_DEF  = 800;
  localparam int unsigned SCREEN_HEIGHT_DEF = 600;

  localparam int unsigned COL_W    = 10;
  localparam int unsigned ROW_W    = 10;
  localparam int unsigned COLOR_W  = 8;
  localparam int unsigned HEIGHT_W = 10;

  // One column of ray-stage output as kept in the buffer.
  typedef struct packed {
    logic [COLOR_W-1:0]  color;
    logic [HEIGHT_W-1:0] height;
    logic                y_side;
  } column_entry_t;

  // Writer side: FILL accepts beats, PENDING holds a complete frame until vertical blanking.
  typedef enum logic {
    WR_FILL    = 1'b0,
    WR_PENDING = 1'b1
  } wr_state_e;

  // Clamp a raw wall height to the number of visible rows.
  function automatic logic [HEIGHT_W-1:0] sat_height(input logic [HEIGHT_W-1:0] h,
                                                      input logic [HEIGHT_W:0]   max_h);
    return ({1'b0, h} > max_h) ? max_h[HEIGHT_W-1:0] : h;
  endfunction

  // Y-side hits are drawn at half brightness to give the walls some depth.
  function automatic logic [COLOR_W-1:0] wall_color(input column_entry_t e);
    return e.y_side ? {1'b0, e.color[COLOR_W-1:1]} : e.color;
  endfunction

endpackage

// File: rtl/column_buffer_if.sv
// Column write channel from the ray stage into the column buffer (valid/ready).
// Latency: none (wiring only).
// Backpressure: slave drives wr_ready; master holds the beat until wr_valid && wr_ready.
interface column_buffer_if;
  import raycast_pkg::*;

  logic                wr_valid;
  logic                wr_ready;
  logic [COL_W-1:0]    wr_col;
  logic [COLOR_W-1:0]  wr_color;
  logic [HEIGHT_W-1:0] wr_height;
  logic                wr_y_side;
  logic                wr_last;

  // Ray stage side.
  modport master (
    output wr_valid,
    input  wr_ready,
    output wr_col,
    output wr_color,
    output wr_height,
    output wr_y_side,
    output wr_last
  );

  // Buffer side.
  modport slave (
    input  wr_valid,
    output wr_ready,
    input  wr_col,
    input  wr_color,
    input  wr_height,
    input  wr_y_side,
    input  wr_last
  );

endinterface

// File: rtl/column_ram.sv
// Two-bank column store: simple dual-port RAM, logical address {bank, col}, packed as bank*WIDTH + col.
// Latency: write lands on the clock edge; read data is registered, valid one cycle after the address.
// Backpressure: none; both ports accept every cycle. Contents are never reset.
module column_ram
  import raycast_pkg::*;
#(
  parameter int unsigned WIDTH = SCREEN_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic             wr_bank_i,
  input  logic [COL_W-1:0] wr_col_i,
  input  column_entry_t    wr_data_i,
  input  logic             rd_bank_i,
  input  logic [COL_W-1:0] rd_col_i,
  output column_entry_t    rd_data_o
);

  localparam int unsigned DEPTH = 2 * WIDTH;
  localparam int unsigned AW    = $clog2(DEPTH);

  // Bank 1 sits directly above bank 0 so the array is exactly two screens deep.
  function automatic logic [AW-1:0] lin_addr(input logic bank, input logic [COL_W-1:0] col);
    return AW'(col) + (bank ? AW'(WIDTH) : AW'(0));
  endfunction

  column_entry_t mem [DEPTH];
  column_entry_t rd_data_q;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  assign wr_addr   = lin_addr(wr_bank_i, wr_col_i);
  assign rd_addr   = lin_addr(rd_bank_i, rd_col_i);
  assign rd_data_o = rd_data_q;

  // Write port: callers only enable it for in-range columns.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_addr] <= wr_data_i;
    end
  end

  // Registered read port; no reset so this maps onto block RAM.
  always_ff @(posedge clk) begin
    rd_data_q <= mem[rd_addr];
  end

endmodule

// File: rtl/column_buffer.sv
// Column buffer: double-banked per-column wall records, expanded to ceiling/wall/floor pixels for the raster.
// Latency: pixel colour/valid appear exactly 2 cycles after pix_x/pix_y/pix_active; writes take 1 cycle.
// Backpressure: wr_ready drops once a full frame is held and returns after frame_start swaps it to display.
module column_buffer
  import raycast_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int unsigned SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter logic [7:0]  CEIL_COLOR    = 8'h11,
  parameter logic [7:0]  FLOOR_COLOR   = 8'h22
) (
  input  logic                clk,
  input  logic                rst,
  column_buffer_if.slave      wr,
  input  logic                frame_start,
  input  logic [COL_W-1:0]    pix_x,
  input  logic [ROW_W-1:0]    pix_y,
  input  logic                pix_active,
  output logic [COLOR_W-1:0]  pix_color,
  output logic                pix_valid,
  output logic                swap_pending
);

  // Geometry held at 11 bits so span arithmetic never wraps for heights up to the screen size.
  localparam logic [COL_W:0]    WIDTH_W  = (COL_W + 1)'(SCREEN_WIDTH);
  localparam logic [HEIGHT_W:0] HEIGHT_W11 = (HEIGHT_W + 1)'(SCREEN_HEIGHT);
  localparam logic [HEIGHT_W:0] HALF_H   = HEIGHT_W11 >> 1;

  // ---------------------------------------------------------------------------
  // Writer FSM and bank control
  // ---------------------------------------------------------------------------
  wr_state_e state_q, state_d;
  logic      rd_bank_q, rd_bank_d;
  logic      loaded_q, loaded_d;

  logic          wr_accept;
  logic          wr_col_ok;
  logic          ram_wr_en;
  column_entry_t wr_entry;

  // Ready is gated by rst so the ray stage sees a stall for the whole reset window.
  assign wr.wr_ready    = (state_q == WR_FILL) && !rst;
  assign swap_pending   = (state_q == WR_PENDING) && !rst;
  assign wr_accept      = wr.wr_valid && wr.wr_ready;

  // Out-of-range columns are consumed (so wr_last still counts) but never reach the RAM.
  assign wr_col_ok      = ({1'b0, wr.wr_col} < WIDTH_W);
  assign ram_wr_en      = wr_accept && wr_col_ok;

  // Saturate on the way in so the read side never sees a span taller than the screen.
  assign wr_entry.color  = wr.wr_color;
  assign wr_entry.height = sat_height(wr.wr_height, HEIGHT_W11);
  assign wr_entry.y_side = wr.wr_y_side;

  // Writer state, displayed bank and loaded flag; reset throws away any partial or pending frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WR_FILL;
      rd_bank_q <= 1'b0;
      loaded_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      loaded_q  <= loaded_d;
    end
  end

  // Next-state: a frame completes on an accepted wr_last and is swapped in on the next frame_start.
  // A frame_start in FILL (including the cycle that completes a frame) leaves the display alone.
  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    loaded_d  = loaded_q;
    unique case (state_q)
      WR_FILL: begin
        if (wr_accept && wr.wr_last) begin
          state_d = WR_PENDING;
        end
      end
      WR_PENDING: begin
        if (frame_start) begin
          state_d   = WR_FILL;
          rd_bank_d = ~rd_bank_q;
          loaded_d  = 1'b1;
        end
      end
      default: state_d = WR_FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic             pix_x_ok;
  logic [COL_W-1:0] rd_col;
  column_entry_t    rd_entry;

  // Off-screen x still issues a harmless in-range read; its result is masked by the empty flag.
  assign pix_x_ok = ({1'b0, pix_x} < WIDTH_W);
  assign rd_col   = pix_x_ok ? pix_x : '0;

  column_ram #(
    .WIDTH (SCREEN_WIDTH)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (ram_wr_en),
    .wr_bank_i (~rd_bank_q),
    .wr_col_i  (wr.wr_col),
    .wr_data_i (wr_entry),
    .rd_bank_i (rd_bank_q),
    .rd_col_i  (rd_col),
    .rd_data_o (rd_entry)
  );

  // ---------------------------------------------------------------------------
  // Read pipeline: stage 1 runs alongside the RAM read, stage 2 is the output register
  // ---------------------------------------------------------------------------
  logic               s1_vld_q;
  logic [ROW_W-1:0]   s1_y_q;
  logic               s1_empty_q;

  // Carry row and the "no wall here" decision next to the RAM's registered read.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_y_q     <= '0;
      s1_empty_q <= 1'b1;
    end else begin
      s1_vld_q   <= pix_active;
      s1_y_q     <= pix_y;
      s1_empty_q <= !pix_x_ok || !loaded_q;
    end
  end

  logic [HEIGHT_W:0]  span_h;
  logic [HEIGHT_W:0]  span_top;
  logic [HEIGHT_W:0]  span_bot;
  logic [ROW_W:0]     y_ext;
  logic [COLOR_W-1:0] pix_color_d;

  // Span compare: an empty column behaves as height 0, so rows split at mid-screen into ceiling/floor.
  always_comb begin
    span_h      = s1_empty_q ? '0 : {1'b0, rd_entry.height};
    span_top    = HALF_H - (span_h >> 1);
    span_bot    = span_top + span_h;
    y_ext       = {1'b0, s1_y_q};
    pix_color_d = '0;
    if (s1_vld_q) begin
      if (y_ext < span_top) begin
        pix_color_d = CEIL_COLOR;
      end else if (y_ext >= span_bot) begin
        pix_color_d = FLOOR_COLOR;
      end else begin
        pix_color_d = wall_color(rd_entry);
      end
    end
  end

  logic               pix_valid_q;
  logic [COLOR_W-1:0] pix_color_q;

  // Output register; colour is forced to zero whenever the pixel is not valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid_q <= 1'b0;
      pix_color_q <= '0;
    end else begin
      pix_valid_q <= s1_vld_q;
      pix_color_q <= pix_color_d;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_color = pix_color_q;

endmodule

// File: tb/tb_column_buffer.sv
// Directed bench for column_buffer: frame fill/swap, span shading and saturation, swap rules, reset.
// Latency: reads are issued one at a time and sampled 2 cycles later.
// Backpressure: writes wait (bounded) on wr_ready.
module tb_column_buffer;
  import raycast_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       pix_active;
  logic [7:0] pix_color;
  logic       pix_valid;
  logic       swap_pending;

  int checks = 0;
  int errors = 0;

  column_buffer_if wr_if ();

  column_buffer #(
    .SCREEN_WIDTH  (800),
    .SCREEN_HEIGHT (600),
    .CEIL_COLOR    (8'h11),
    .FLOOR_COLOR   (8'h22)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr           (wr_if),
    .frame_start  (frame_start),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_active   (pix_active),
    .pix_color    (pix_color),
    .pix_valid    (pix_valid),
    .swap_pending (swap_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_beat(input int col, input logic [7:0] color, input int height,
                            input logic ys, input logic last);
    int n;
    n = 0;
    wr_if.wr_valid  = 1'b1;
    wr_if.wr_col    = 10'(col);
    wr_if.wr_color  = color;
    wr_if.wr_height = 10'(height);
    wr_if.wr_y_side = ys;
    wr_if.wr_last   = last;
    while (!wr_if.wr_ready && n < 20) begin
      step();
      n++;
    end
    if (n == 20) check("wr_ready_timeout", 32'(wr_if.wr_ready), 32'd1);
    step();
    wr_if.wr_valid = 1'b0;
    wr_if.wr_last  = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic chk_pix(input string tag, input int x, input int y, input logic [7:0] exp);
    logic [7:0] c;
    logic       v;
    pix_x      = 10'(x);
    pix_y      = 10'(y);
    pix_active = 1'b1;
    step();
    pix_active = 1'b0;
    step();
    c = pix_color;
    v = pix_valid;
    check($sformatf("%s x=%0d y=%0d", tag, x, y), {23'd0, v, c}, {23'd0, 1'b1, exp});
  endtask

  task automatic chk_bank(input string tag, input logic exp);
    check(tag, 32'(dut.rd_bank_q), 32'(exp));
  endtask

  initial begin
    rst             = 1'b1;
    frame_start     = 1'b0;
    pix_x           = '0;
    pix_y           = '0;
    pix_active      = 1'b0;
    wr_if.wr_valid  = 1'b0;
    wr_if.wr_col    = '0;
    wr_if.wr_color  = '0;
    wr_if.wr_height = '0;
    wr_if.wr_y_side = 1'b0;
    wr_if.wr_last   = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_wr_ready", 32'(wr_if.wr_ready), 32'd0);
    check("rst_swap_pending", 32'(swap_pending), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_color", 32'(pix_color), 32'd0);
    chk_bank("rst_rd_bank", 1'b0);
    rst = 1'b0;
    #1;
    check("wr_ready_after_rst", 32'(wr_if.wr_ready), 32'd1);
    step();

    // Nothing loaded yet: ceiling above mid-screen, floor from row 300
    chk_pix("empty", 5, 0, 8'h11);
    chk_pix("empty", 5, 299, 8'h11);
    chk_pix("empty", 5, 300, 8'h22);
    chk_pix("empty", 5, 599, 8'h22);
    chk_pix("empty_oob", 900, 10, 8'h11);

    // Frame 1: every column colour 40, height 200 -> wall rows 200..399
    for (int c = 0; c < 800; c++) write_beat(c, 8'h40, 200, 1'b0, c == 799);
    check("f1_swap_pending", 32'(swap_pending), 32'd1);
    check("f1_wr_ready_pending", 32'(wr_if.wr_ready), 32'd0);
    chk_pix("f1_not_yet", 10, 250, 8'h11);
    pulse_fs();
    check("f1_swap_cleared", 32'(swap_pending), 32'd0);
    check("f1_wr_ready", 32'(wr_if.wr_ready), 32'd1);
    chk_bank("f1_rd_bank", 1'b1);
    for (int y = 0; y < 600; y++)
      chk_pix("f1_x0", 0, y, (y < 200) ? 8'h11 : ((y < 400) ? 8'h40 : 8'h22));
    chk_pix("f1_x799", 799, 199, 8'h11);
    chk_pix("f1_x799", 799, 200, 8'h40);
    chk_pix("f1_x799", 799, 399, 8'h40);
    chk_pix("f1_x799", 799, 400, 8'h22);
    chk_pix("f1_oob", 800, 299, 8'h11);
    chk_pix("f1_oob", 800, 300, 8'h22);
    chk_pix("f1_oob", 1023, 0, 8'h11);

    // Exact 2-cycle latency and zero colour when not valid
    step();
    pix_x = 10'd0;
    pix_y = 10'd250;
    pix_active = 1'b1;
    step();
    pix_active = 1'b0;
    check("lat_n1", {23'd0, pix_valid, pix_color}, 32'h0);
    step();
    check("lat_n2", {23'd0, pix_valid, pix_color}, {23'd0, 1'b1, 8'h40});
    step();
    check("lat_n3", {23'd0, pix_valid, pix_color}, 32'h0);

    // frame_start with nothing pending: no toggle, same picture
    pulse_fs();
    chk_bank("nopend_rd_bank", 1'b1);
    chk_pix("nopend", 0, 250, 8'h40);
    chk_pix("nopend", 0, 199, 8'h11);

    // Frame 2 into bank 0: shading, saturation, zero/one/odd heights
    write_beat(5, 8'hF2, 600, 1'b1, 1'b0);
    write_beat(6, 8'h5A, 1023, 1'b0, 1'b0);
    write_beat(7, 8'h77, 0, 1'b0, 1'b0);
    write_beat(8, 8'h33, 1, 1'b0, 1'b0);
    write_beat(9, 8'h66, 601, 1'b0, 1'b0);
    write_beat(10, 8'hC8, 201, 1'b1, 1'b0);
    pulse_fs();
    chk_bank("midfill_rd_bank", 1'b1);
    check("midfill_swap_pending", 32'(swap_pending), 32'd0);
    chk_pix("midfill", 5, 0, 8'h11);
    write_beat(1023, 8'hEE, 100, 1'b0, 1'b1);
    check("f2_oob_last_pending", 32'(swap_pending), 32'd1);
    pulse_fs();
    chk_bank("f2_rd_bank", 1'b0);
    for (int y = 0; y < 600; y++) chk_pix("f2_shade_x5", 5, y, 8'h79);
    for (int y = 0; y < 600; y++) chk_pix("f2_sat_x6", 6, y, 8'h5A);
    chk_pix("f2_h0", 7, 0, 8'h11);
    chk_pix("f2_h0", 7, 299, 8'h11);
    chk_pix("f2_h0", 7, 300, 8'h22);
    chk_pix("f2_h0", 7, 599, 8'h22);
    chk_pix("f2_h1", 8, 299, 8'h11);
    chk_pix("f2_h1", 8, 300, 8'h33);
    chk_pix("f2_h1", 8, 301, 8'h22);
    chk_pix("f2_h601", 9, 0, 8'h66);
    chk_pix("f2_h601", 9, 599, 8'h66);
    chk_pix("f2_h201", 10, 199, 8'h11);
    chk_pix("f2_h201", 10, 200, 8'h64);
    chk_pix("f2_h201", 10, 400, 8'h64);
    chk_pix("f2_h201", 10, 401, 8'h22);

    // Frame 3: stall while pending, then wr_last coincident with frame_start
    write_beat(0, 8'h90, 200, 1'b0, 1'b1);
    check("f3_pending", 32'(swap_pending), 32'd1);
    wr_if.wr_valid  = 1'b1;
    wr_if.wr_col    = 10'd1;
    wr_if.wr_color  = 8'hA5;
    wr_if.wr_height = 10'd400;
    wr_if.wr_y_side = 1'b0;
    wr_if.wr_last   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_wr_ready", 32'(wr_if.wr_ready), 32'd0);
      step();
    end
    frame_start = 1'b1;
    check("hold_wr_ready_fs", 32'(wr_if.wr_ready), 32'd0);
    step();
    frame_start    = 1'b0;
    wr_if.wr_valid = 1'b0;
    chk_bank("f3_rd_bank", 1'b1);
    check("f3_swap_cleared", 32'(swap_pending), 32'd0);
    check("f3_wr_ready", 32'(wr_if.wr_ready), 32'd1);
    chk_pix("f3", 0, 250, 8'h90);
    chk_pix("f3", 0, 199, 8'h11);
    chk_pix("f3_old_col1", 1, 250, 8'h40);
    wr_if.wr_valid = 1'b1;
    frame_start    = 1'b1;
    step();
    wr_if.wr_valid = 1'b0;
    wr_if.wr_last  = 1'b0;
    frame_start    = 1'b0;
    check("coinc_pending", 32'(swap_pending), 32'd1);
    chk_bank("coinc_rd_bank", 1'b1);
    chk_pix("coinc_noswap", 1, 250, 8'h40);
    pulse_fs();
    chk_bank("coinc_next_rd_bank", 1'b0);
    chk_pix("f4_col1", 1, 99, 8'h11);
    chk_pix("f4_col1", 1, 100, 8'hA5);
    chk_pix("f4_col1", 1, 499, 8'hA5);
    chk_pix("f4_col1", 1, 500, 8'h22);
    chk_pix("f4_col5", 5, 300, 8'h79);

    // Reset while pending discards the frame and the display goes blank
    write_beat(2, 8'h55, 300, 1'b0, 1'b1);
    check("pre_rst_pending", 32'(swap_pending), 32'd1);
    rst = 1'b1;
    step();
    check("rst1_swap_pending", 32'(swap_pending), 32'd0);
    check("rst1_wr_ready", 32'(wr_if.wr_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_wr_ready", 32'(wr_if.wr_ready), 32'd1);
    check("post_rst_swap_pending", 32'(swap_pending), 32'd0);
    chk_bank("post_rst_rd_bank", 1'b0);
    step();
    chk_pix("post_rst", 1, 100, 8'h11);
    chk_pix("post_rst", 1, 450, 8'h22);
    chk_pix("post_rst", 5, 300, 8'h22);
    pulse_fs();
    chk_bank("post_rst_fs_rd_bank", 1'b0);
    chk_pix("post_rst_fs", 5, 300, 8'h22);
    write_beat(1, 8'hC3, 600, 1'b0, 1'b1);
    pulse_fs();
    chk_bank("new_frame_rd_bank", 1'b1);
    chk_pix("new_frame", 1, 0, 8'hC3);
    chk_pix("new_frame", 1, 599, 8'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/column_buffer.md
COLUMN_BUFFER -- requirements
Module: column_buffer

Interface
REQ-001 Parameter SCREEN_WIDTH, default 800, number of screen columns.
REQ-002 Parameter SCREEN_HEIGHT, default 600, number of screen rows.
REQ-003 Parameter CEIL_COLOR, default 8'h11, colour of rows above the wall span.
REQ-004 Parameter FLOOR_COLOR, default 8'h22, colour of rows below the wall span.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 wr_valid  input  1  column result present.
REQ-008 wr_ready  output  1  buffer accepts the column result.
REQ-009 wr_col  input  10  screen column index of the result.
REQ-010 wr_color  input  8  wall colour from the ray stage.
REQ-011 wr_height  input  10  wall height in rows from the ray stage.
REQ-012 wr_y_side  input  1  wall hit on a Y side.
REQ-013 wr_last  input  1  qualifies the final column of a frame.
REQ-014 frame_start  input  1  one-cycle pulse at the start of vertical blanking.
REQ-015 pix_x, pix_y  input  10 each  raster coordinate being requested.
REQ-016 pix_active  input  1  raster coordinate is in the visible area.
REQ-017 pix_color  output  8  pixel colour for the requested coordinate.
REQ-018 pix_valid  output  1  pix_color is valid.
REQ-019 swap_pending  output  1  a completed frame is waiting for frame_start.

Function
REQ-020 The block SHALL hold two banks of SCREEN_WIDTH entries {color, height, y_side}; the display reads rd_bank and writes go to the other bank.
REQ-021 A write SHALL occur on wr_valid && wr_ready; when wr_col >= SCREEN_WIDTH, the beat SHALL be accepted and its data dropped, but wr_last SHALL still take effect.
REQ-022 The writer FSM SHALL have two states. FILL: wr_ready=1; an accepted beat with wr_last moves the FSM to PENDING. PENDING: wr_ready=0 and swap_pending=1.
REQ-023 In PENDING, a frame_start pulse SHALL toggle rd_bank, set the loaded flag, and return the FSM to FILL in the same cycle.
REQ-024 A frame_start that arrives while in FILL SHALL NOT swap; the display SHALL repeat the current bank.
REQ-025 When wr_last is accepted in the same cycle as frame_start, the swap SHALL NOT occur in that cycle; it SHALL occur at the next frame_start.
REQ-026 The read path SHALL have a fixed 2-cycle latency: pix_valid and pix_color in cycle N+2 correspond to pix_x, pix_y and pix_active sampled in cycle N.
REQ-027 pix_valid SHALL equal pix_active delayed by 2 cycles; pix_color SHALL be 0 whenever pix_valid=0.
REQ-028 Stored height SHALL saturate to SCREEN_HEIGHT.
REQ-029 The wall span SHALL be computed as follows, using unsigned 11-bit arithmetic:
- h = the saturated height
- top = SCREEN_HEIGHT/2 - h/2
- bot = top + h, exclusive
REQ-030 The pixel colour SHALL be selected as follows:
- pix_y < top: CEIL_COLOR
- pix_y >= bot: FLOOR_COLOR
- otherwise, the wall colour; when y_side=1 the wall colour SHALL be shaded to {1'b0, color[7:1]}.
REQ-031 When h=0, no wall pixel SHALL be produced for that column.
REQ-032 When pix_x >= SCREEN_WIDTH, or the loaded flag is 0, the wall span SHALL be treated as empty and only ceiling/floor colours produced.

Reset
REQ-033 While rst=1, the block SHALL hold:
- FSM = FILL
- rd_bank = 0
- loaded = 0
- swap_pending = 0
- pix_valid = 0
- pix_color = 0
- the read pipeline cleared
REQ-034 wr_ready SHALL be 0 while rst=1 and SHALL be 1 in the first cycle after reset is released.
REQ-035 RAM contents SHALL NOT be reset.
REQ-036 A reset asserted mid-frame SHALL discard any partially written or pending frame.

Structure
REQ-037 SCREEN_WIDTH and SCREEN_HEIGHT defaults and the column_entry_t struct {color[7:0], height[9:0], y_side} SHALL live in raycast_pkg, shared with process_element.
REQ-038 Storage SHALL be one sub-module, column_ram: a simple dual-port memory of depth 2*SCREEN_WIDTH, with 1-cycle registered read and address {bank, col}.
REQ-039 The FSM, the span compare, and the output register SHALL reside in column_buffer.

Verification
REQ-040 The bench SHALL write 800 columns (color=8'h40, height=200, y_side=0), the last with wr_last, then pulse frame_start; it SHALL then check:
- rows 0..199 return 8'h11
- rows 200..399 return 8'h40
- rows 400..599 return 8'h22
REQ-041 The bench SHALL write column 5 with y_side=1, color=8'hF2, height=600, and check that every row of x=5 returns 8'h79.
REQ-042 The bench SHALL write height=1023 and check that it saturates: the whole column is wall colour and no ceiling or floor appears.
REQ-043 The bench SHALL pulse frame_start with no frame pending and check that the display is unchanged and rd_bank does not toggle.
REQ-044 The bench SHALL complete a frame, hold wr_valid=1, and check that wr_ready=0 until frame_start; wr_last coincident with frame_start SHALL swap only at the next pulse.
REQ-045 The bench SHALL assert rst for 1 cycle while PENDING and check that swap_pending=0, wr_ready=1, and the output is ceiling/floor only until a new frame is swapped in.
